// File: rtl/lc3b_types.sv
// Shared types for the LC-3b L1 cache: controller state encoding.
package lc3b_types;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WB    = 2'd1,
    S_ALLOC = 2'd2
  } lc3b_cache_state;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [width-1:0] count
);

  logic [width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// Controller for the 2-way write-back/write-allocate L1: sequences hit, writeback and
// line fill, decodes datapath strobes from state and inputs, and keeps perf counters.
module cache_control
  import lc3b_types::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic             tag_match,
  input  logic             tag_sel,
  input  logic             valid,
  input  logic             dirty,
  input  logic             lru_out,
  output logic             write_one,
  output logic             write_two,
  output logic             write_dirty_one,
  output logic             write_dirty_two,
  output logic             dirty_one_in,
  output logic             dirty_two_in,
  output logic             lru_write,
  output logic             writemux_sel,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  lc3b_cache_state state_q, state_d;
  logic req, hit;
  logic hit_inc, miss_inc, wb_inc;

  assign req = mem_read | mem_write;
  assign hit = tag_match & valid;

  always_comb begin
    state_d         = state_q;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    write_one       = 1'b0;
    write_two       = 1'b0;
    write_dirty_one = 1'b0;
    write_dirty_two = 1'b0;
    dirty_one_in    = 1'b0;
    dirty_two_in    = 1'b0;
    lru_write       = 1'b0;
    writemux_sel    = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    wb_inc          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req && hit) begin
          mem_resp  = 1'b1;
          lru_write = 1'b1;
          hit_inc   = 1'b1;
          // A simultaneous read+write is serviced as a write.
          if (mem_write) begin
            writemux_sel    = 1'b1;
            write_one       = ~tag_sel;
            write_two       = tag_sel;
            write_dirty_one = ~tag_sel;
            write_dirty_two = tag_sel;
            dirty_one_in    = ~tag_sel;
            dirty_two_in    = tag_sel;
          end
        end else if (req) begin
          miss_inc = 1'b1;
          state_d  = dirty ? S_WB : S_ALLOC;
        end
      end
      S_WB: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          wb_inc  = 1'b1;
          state_d = S_ALLOC;
        end
      end
      S_ALLOC: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          write_one       = ~lru_out;
          write_two       = lru_out;
          write_dirty_one = ~lru_out;
          write_dirty_two = lru_out;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(.width(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.width(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (miss_inc),
    .count (miss_count)
  );

  sat_counter #(.width(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (wb_inc),
    .count (wb_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: datapath inputs driven by hand, strobes and counters
// compared against hand-computed values. A second instance with CNT_W=2 checks saturation.
module tb_cache_control;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_read, mem_write, pmem_resp;
  logic tag_match, tag_sel, valid, dirty, lru_out, perf_clr;

  logic mem_resp, pmem_read, pmem_write;
  logic write_one, write_two, write_dirty_one, write_dirty_two;
  logic dirty_one_in, dirty_two_in, lru_write, writemux_sel;
  logic [15:0] hit_count, miss_count, wb_count;

  logic s_mem_resp, s_pmem_read, s_pmem_write;
  logic s_write_one, s_write_two, s_write_dirty_one, s_write_dirty_two;
  logic s_dirty_one_in, s_dirty_two_in, s_lru_write, s_writemux_sel;
  logic [1:0] s_hit_count, s_miss_count, s_wb_count;

  // {mem_resp, pmem_read, pmem_write, write_one, write_two, write_dirty_one,
  //  write_dirty_two, dirty_one_in, dirty_two_in, lru_write, writemux_sel}
  logic [10:0] strobes;
  assign strobes = {mem_resp, pmem_read, pmem_write, write_one, write_two, write_dirty_one,
                    write_dirty_two, dirty_one_in, dirty_two_in, lru_write, writemux_sel};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cache_control #(.CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_resp       (pmem_resp),
    .tag_match       (tag_match),
    .tag_sel         (tag_sel),
    .valid           (valid),
    .dirty           (dirty),
    .lru_out         (lru_out),
    .write_one       (write_one),
    .write_two       (write_two),
    .write_dirty_one (write_dirty_one),
    .write_dirty_two (write_dirty_two),
    .dirty_one_in    (dirty_one_in),
    .dirty_two_in    (dirty_two_in),
    .lru_write       (lru_write),
    .writemux_sel    (writemux_sel),
    .perf_clr        (perf_clr),
    .hit_count       (hit_count),
    .miss_count      (miss_count),
    .wb_count        (wb_count)
  );

  cache_control #(.CNT_W(2)) dut_sat (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_resp        (s_mem_resp),
    .pmem_read       (s_pmem_read),
    .pmem_write      (s_pmem_write),
    .pmem_resp       (pmem_resp),
    .tag_match       (tag_match),
    .tag_sel         (tag_sel),
    .valid           (valid),
    .dirty           (dirty),
    .lru_out         (lru_out),
    .write_one       (s_write_one),
    .write_two       (s_write_two),
    .write_dirty_one (s_write_dirty_one),
    .write_dirty_two (s_write_dirty_two),
    .dirty_one_in    (s_dirty_one_in),
    .dirty_two_in    (s_dirty_two_in),
    .lru_write       (s_lru_write),
    .writemux_sel    (s_writemux_sel),
    .perf_clr        (perf_clr),
    .hit_count       (s_hit_count),
    .miss_count      (s_miss_count),
    .wb_count        (s_wb_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_counts(input string tag, input int h, input int m, input int w);
    check({tag, "_hit"},  32'(hit_count),  32'(h));
    check({tag, "_miss"}, 32'(miss_count), 32'(m));
    check({tag, "_wb"},   32'(wb_count),   32'(w));
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    tag_match = 1'b0; tag_sel = 1'b0; valid = 1'b0; dirty = 1'b0; lru_out = 1'b0;
    perf_clr = 1'b0;
    #2;
    check("reset_strobes", 32'(strobes), 32'h0);
    check_counts("reset", 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    // Cold read miss, clean victim (way one), fill after 5 pmem cycles, then hit.
    mem_read = 1'b1;
    #1 check("t1_lookup", 32'(strobes), 32'h000);
    @(negedge clk) #1 check("t1_alloc", 32'(strobes), 32'h200);
    check("t1_miss", 32'(miss_count), 32'd1);
    repeat (3) @(negedge clk);
    #1 check("t1_alloc_hold", 32'(strobes), 32'h200);
    @(negedge clk) pmem_resp = 1'b1;
    #1 check("t1_fill", 32'(strobes), 32'h2A0);
    @(negedge clk) pmem_resp = 1'b0; tag_match = 1'b1; valid = 1'b1;
    #1 check("t1_hit", 32'(strobes), 32'h402);
    @(negedge clk) mem_read = 1'b0;
    #1 check("t1_idle", 32'(strobes), 32'h000);
    check_counts("t1", 1, 1, 0);

    // Read hit again: same-cycle response, no pmem activity.
    mem_read = 1'b1;
    #1 check("t2_hit", 32'(strobes), 32'h402);

    // Write hits into way one, way two, then read+write treated as write (way two).
    @(negedge clk) mem_read = 1'b0; mem_write = 1'b1; tag_sel = 1'b0;
    #1 check("t3_wr_way1", 32'(strobes), 32'h4AB);
    @(negedge clk) tag_sel = 1'b1;
    #1 check("t3_wr_way2", 32'(strobes), 32'h457);
    @(negedge clk) mem_read = 1'b1;
    #1 check("t3_rw_way2", 32'(strobes), 32'h457);
    @(negedge clk) mem_read = 1'b0; mem_write = 1'b0;
    #1 check_counts("t3", 5, 1, 0);

    // Dirty miss: writeback of way two, then fill into way two.
    mem_read = 1'b1; tag_match = 1'b0; dirty = 1'b1; lru_out = 1'b1;
    #1 check("t4_lookup", 32'(strobes), 32'h000);
    @(negedge clk) #1 check("t4_wb", 32'(strobes), 32'h100);
    @(negedge clk) pmem_resp = 1'b1;
    #1 check("t4_wb_resp", 32'(strobes), 32'h100);
    @(negedge clk) pmem_resp = 1'b0;
    #1 check("t4_alloc", 32'(strobes), 32'h200);
    check("t4_wbcnt", 32'(wb_count), 32'd1);
    @(negedge clk) pmem_resp = 1'b1;
    #1 check("t4_fill", 32'(strobes), 32'h250);
    @(negedge clk) pmem_resp = 1'b0; tag_match = 1'b1; dirty = 1'b0;
    #1 check("t4_hit", 32'(strobes), 32'h402);
    @(negedge clk) mem_read = 1'b0;
    #1 check_counts("t4", 6, 2, 1);

    // pmem_resp in idle is ignored.
    pmem_resp = 1'b1;
    #1 check("idle_resp", 32'(strobes), 32'h000);
    @(negedge clk) pmem_resp = 1'b0;
    #1 check("idle_stay", 32'(strobes), 32'h000);

    // Tag match with invalid line is a miss; request dropped mid-fill.
    mem_read = 1'b1; tag_match = 1'b1; valid = 1'b0; lru_out = 1'b0;
    #1 check("drop_lookup", 32'(strobes), 32'h000);
    @(negedge clk) mem_read = 1'b0;
    #1 check("drop_alloc", 32'(strobes), 32'h200);
    @(negedge clk) pmem_resp = 1'b1;
    #1 check("drop_fill", 32'(strobes), 32'h2A0);
    @(negedge clk) pmem_resp = 1'b0;
    #1 check("drop_idle", 32'(strobes), 32'h000);
    check_counts("drop", 6, 3, 1);

    // Async reset in the middle of a fill.
    mem_read = 1'b1; tag_match = 1'b0;
    @(negedge clk) #1 check("t5_alloc", 32'(strobes), 32'h200);
    #1 rst_n = 1'b0;
    #1 check("t5_rst_pread", 32'(pmem_read), 32'h0);
    check_counts("t5", 0, 0, 0);
    mem_read = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    mem_read = 1'b1; tag_match = 1'b1; valid = 1'b1;
    #1 check("t5_idle_hit", 32'(strobes), 32'h402);

    // Five hits saturate a 2-bit counter; clear beats a concurrent hit.
    repeat (5) @(negedge clk);
    #1 check("t6_hit16", 32'(hit_count), 32'd5);
    check("t6_hit2_sat", 32'(s_hit_count), 32'd3);
    perf_clr = 1'b1;
    @(negedge clk) #1 check("t6_clr16", 32'(hit_count), 32'd0);
    check("t6_clr2", 32'(s_hit_count), 32'd0);
    perf_clr = 1'b0; mem_read = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
